// File: rtl/vga_frame_sequencer_if.sv
// vga_frame_sequencer_if: raster timing outputs and per-frame update handshake
interface vga_frame_sequencer_if;
  logic       pause;
  logic       upd_ack;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       hsync;
  logic       vsync;
  logic       display_on;
  logic       line_req;
  logic       upd_req;
  logic       upd_sel;
  logic [7:0] frame_cnt;
  logic       overrun;
  modport master (
    input  pause, upd_ack,
    output hpos, vpos, hsync, vsync, display_on, line_req, upd_req, upd_sel, frame_cnt, overrun
  );
  modport slave (
    output pause, upd_ack,
    input  hpos, vpos, hsync, vsync, display_on, line_req, upd_req, upd_sel, frame_cnt, overrun
  );
endinterface

// File: rtl/vga_frame_sequencer.sv
// vga_frame_sequencer: VGA raster timing plus the per-frame angle update schedule
module vga_frame_sequencer #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int LINE_LEAD = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  vga_frame_sequencer_if.master  bus
);
  localparam logic [9:0] H_LAST = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] HS_BEG = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic [9:0] H_VIS  = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS  = 10'(V_DISPLAY);
  localparam logic [9:0] H_LEAD = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - LINE_LEAD);

  typedef enum logic [1:0] {IDLE, REQ_A, REQ_B} state_t;

  state_t     state, state_n;
  logic [9:0] hpos, vpos, v_next;
  logic [7:0] frame_cnt;
  logic       overrun, h_last, v_last, vbs, done, abort;

  assign h_last = hpos == H_LAST;
  assign v_last = vpos == V_LAST;
  assign v_next = v_last ? '0 : vpos + 10'd1;
  assign vbs    = hpos == '0 && vpos == V_VIS;

  // Raster counters: hpos every cycle, vpos on each line wrap
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hpos <= '0;
      vpos <= '0;
    end else begin
      hpos <= h_last ? '0 : hpos + 10'd1;
      vpos <= h_last ? v_next : vpos;
    end

  // Schedule next state; the end-of-frame abort takes priority over a same-cycle ack
  always_comb begin
    state_n = state;
    done    = 1'b0;
    abort   = 1'b0;
    if (state != IDLE && h_last && v_last) begin
      state_n = IDLE;
      abort   = 1'b1;
    end else if (state == IDLE) begin
      state_n = (vbs && !bus.pause) ? REQ_A : IDLE;
    end else if (bus.upd_ack) begin
      state_n = state == REQ_A ? REQ_B : IDLE;
      done    = state == REQ_B;
    end
  end

  // Schedule state, completed-frame count and sticky overrun flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      frame_cnt <= '0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      frame_cnt <= frame_cnt + 8'(done);
      overrun   <= overrun | abort;
    end

  assign bus.hpos       = hpos;
  assign bus.vpos       = vpos;
  assign bus.hsync      = !(hpos >= HS_BEG && hpos < HS_END);
  assign bus.vsync      = !(vpos >= VS_BEG && vpos < VS_END);
  assign bus.display_on = hpos < H_VIS && vpos < V_VIS;
  assign bus.line_req   = hpos == H_LEAD && v_next < V_VIS;
  assign bus.upd_req    = state != IDLE;
  assign bus.upd_sel    = state == REQ_B;
  assign bus.frame_cnt  = frame_cnt;
  assign bus.overrun    = overrun;
endmodule

// File: tb/tb_vga_frame_sequencer.sv
// tb_vga_frame_sequencer: reduced-size raster, position-based model plus directed literal checks
module tb_vga_frame_sequencer;
  localparam int HD = 16, HF = 2, HS = 4, HB = 2;
  localparam int VD = 8, VF = 2, VS = 2, VB = 2;
  localparam int LL = 4;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   m_t, m_rem, m_cnt;
  logic m_ovr;

  vga_frame_sequencer_if bus ();

  vga_frame_sequencer #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .LINE_LEAD(LL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  function automatic int mh(int t);
    return t % HT;
  endfunction

  function automatic int mv(int t);
    return (t / HT) % VT;
  endfunction

  // Model: position is elapsed cycles since reset; the schedule is the number of acks still owed
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_t   <= 0;
      m_rem <= 0;
      m_cnt <= 0;
      m_ovr <= 1'b0;
    end else begin
      m_t <= m_t + 1;
      if (m_rem != 0 && mh(m_t) == HT - 1 && mv(m_t) == VT - 1) begin
        m_rem <= 0;
        m_ovr <= 1'b1;
      end else if (m_rem == 0) begin
        if (mh(m_t) == 0 && mv(m_t) == VD && !bus.pause) m_rem <= 2;
      end else if (bus.upd_ack) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) m_cnt <= (m_cnt + 1) % 256;
      end
    end

  function automatic logic [32:0] model_out();
    int h, v;
    logic hs_o, vs_o, de, lr;
    h    = mh(m_t);
    v    = mv(m_t);
    hs_o = !(h >= HD + HF && h < HD + HF + HS);
    vs_o = !(v >= VD + VF && v < VD + VF + VS);
    de   = h < HD && v < VD;
    lr   = h == HT - LL && ((v + 1) % VT) < VD;
    return {10'(h), 10'(v), hs_o, vs_o, de, lr, m_rem != 0, m_rem == 1, 8'(m_cnt), m_ovr};
  endfunction

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    logic [32:0] act, exp;
    act = {bus.hpos, bus.vpos, bus.hsync, bus.vsync, bus.display_on, bus.line_req,
           bus.upd_req, bus.upd_sel, bus.frame_cnt, bus.overrun};
    exp = model_out();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL model t=%0d got=%h want=%h", m_t, act, exp);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic goto(input int target);
    for (int k = 0; k < 5000 && m_t != target; k++) @(negedge clk);
    if (m_t != target) begin
      $display("FAIL goto got=%0d want=%0d", m_t, target);
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1);
    end
  endtask

  initial begin
    int pulses;
    bus.pause   = 1'b0;
    bus.upd_ack = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_hpos", 32'(bus.hpos), 0);
    chk("rst_sync", {bus.hsync, bus.vsync, bus.display_on, bus.line_req}, 32'b1110);
    chk("rst_upd", {bus.upd_req, bus.upd_sel, bus.overrun}, 0);
    chk("rst_cnt", 32'(bus.frame_cnt), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < HT * VT; i++) begin
      @(negedge clk);
      pulses += int'(bus.line_req);
      if (i == 15)  chk("de_last_vis", 32'(bus.display_on), 1);
      if (i == 16)  chk("de_drop", 32'(bus.display_on), 0);
      if (i == 17)  chk("hsync_pre", 32'(bus.hsync), 1);
      if (i == 18)  chk("hsync_beg", 32'(bus.hsync), 0);
      if (i == 21)  chk("hsync_end", 32'(bus.hsync), 0);
      if (i == 22)  chk("hsync_post", 32'(bus.hsync), 1);
      if (i == 188) chk("lr_none_v7", 32'(bus.line_req), 0);
      if (i == 193) chk("upd_a", {bus.upd_req, bus.upd_sel}, 32'b10);
      if (i == 194) chk("upd_b", {bus.upd_req, bus.upd_sel}, 32'b11);
      if (i == 195) chk("upd_done", {bus.upd_req, bus.frame_cnt}, 32'd1);
      if (i == 240) chk("vsync_beg", 32'(bus.vsync), 0);
      if (i == 287) chk("vsync_end", 32'(bus.vsync), 0);
      if (i == 288) chk("vsync_post", 32'(bus.vsync), 1);
      if (i == 332) chk("lr_v13", 32'(bus.line_req), 1);
    end
    chk("lr_count", 32'(pulses), 32'(VD));
    goto(336);
    chk("frame_wrap", {bus.hpos, bus.vpos}, 0);
    bus.upd_ack = 1'b0;
    goto(529);
    chk("hold_a", {bus.upd_req, bus.upd_sel}, 32'b10);
    goto(530);
    bus.upd_ack = 1'b1;
    goto(531);
    bus.upd_ack = 1'b0;
    goto(545);
    chk("hold_b", {bus.upd_req, bus.upd_sel}, 32'b11);
    goto(551);
    bus.upd_ack = 1'b1;
    goto(552);
    bus.upd_ack = 1'b0;
    goto(560);
    chk("slow_cnt", 32'(bus.frame_cnt), 2);
    chk("slow_ovr", {bus.upd_req, bus.overrun}, 0);
    goto(700);
    bus.pause   = 1'b1;
    bus.upd_ack = 1'b1;
    goto(870);
    chk("pause_req", 32'(bus.upd_req), 0);
    chk("pause_cnt", 32'(bus.frame_cnt), 2);
    goto(900);
    bus.pause = 1'b0;
    goto(1210);
    chk("resume_cnt", 32'(bus.frame_cnt), 3);
    goto(1300);
    bus.upd_ack = 1'b0;
    goto(1679);
    chk("dl_before", {bus.upd_req, bus.overrun}, 32'b10);
    goto(1680);
    chk("dl_abort", {bus.upd_req, bus.overrun}, 32'b01);
    chk("dl_cnt", 32'(bus.frame_cnt), 3);
    goto(1873);
    chk("restart", 32'(bus.upd_req), 1);
    bus.upd_ack = 1'b1;
    goto(1885);
    chk("post_ovr_cnt", {bus.frame_cnt, bus.overrun}, {8'd4, 1'b1});
    bus.upd_ack = 1'b0;
    goto(2215);
    chk("pre_rst_req", 32'(bus.upd_req), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_req", {bus.upd_req, bus.overrun}, 0);
    chk("async_pos", {bus.hpos, bus.frame_cnt}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("after_rst", {bus.hpos, bus.overrun}, {10'd4, 1'b0});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
